task_step_sequencer: RTL and testbench

//  Parametrised successor of the capture/upload scheduler: drives N_TASKS sub-blocks (config, capture,
//  RAM write, RAM read, UART tx, ...) through an en/done handshake in fixed index order, repeats a loop

---
 rtl/task_seq_pkg.sv | 28 ++
 rtl/task_timeout_counter.sv | 36 +++
 rtl/task_step_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_task_step_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_seq_pkg.sv
// Shared types and helpers for the task step sequencer.
// Contents: state enum, default parameter values, index-width helper.
package task_seq_pkg;

  localparam int unsigned DEF_N_TASKS    = 6;
  localparam int unsigned DEF_LOOP_FIRST = 3;
  localparam int unsigned DEF_LOOP_LAST  = 4;
  localparam int unsigned DEF_LOOP_CNT_W = 16;
  localparam int unsigned DEF_TIMEOUT_W  = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  // Bits needed to index n items; never less than 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/task_timeout_counter.sv
// Per-task watchdog used by task_step_sequencer when TASK_SEQ_TIMEOUT_EN is defined.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_clear         restart the count (asserted while a task is being issued)
//   i_run           count this cycle (asserted while waiting for done)
//   i_limit         cycle limit, 0 = unlimited
//   o_expired_c     combinational: this is the limit-th waiting cycle
// The module body exists only when TASK_SEQ_TIMEOUT_EN is defined.
`ifdef TASK_SEQ_TIMEOUT_EN
module task_timeout_counter #(
  parameter int unsigned W = 24
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_run,
  input  logic [W-1:0] i_limit,
  output logic         o_expired_c
);

  logic [W-1:0] r_cnt;

  // Counts waiting cycles already elapsed; holds at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  // r_cnt excludes the current cycle, so compare against limit-1.
  assign o_expired_c = i_run && (i_limit != '0) && (r_cnt == (i_limit - W'(1)));

endmodule
`endif

// File: rtl/task_step_sequencer.sv
// Drives N_TASKS sub-blocks through an en/done handshake in ascending index order,
// repeating the window [LOOP_FIRST..LOOP_LAST] until iLoopExit is seen at its end.
// Optional feature macro: TASK_SEQ_TIMEOUT_EN (per-task timeout -> ERR state).
// Ports:
//   iClk, iRst   clock, synchronous active-high reset
//   iStart       start pulse (honoured in IDLE/DONE/ERR)
//   iAbort       return to IDLE next cycle, overrides everything
//   iSkipMask    per-task skip bits, latched at start
//   iLoopExit    leave the loop window when sampled at its last task
//   iTimeout     per-task cycle limit latched at start (0 = none)
//   iTaskDone    done levels; only the current task's bit is looked at
//   oTaskEn      one-hot-or-zero enable of the current task
//   oCurTask     current task index
//   oLoopCnt     completed loop iterations, saturating
//   oBusy/oDone/oErr  state flags; oErrTask = task that timed out
module task_step_sequencer
  import task_seq_pkg::*;
#(
  parameter int unsigned N_TASKS    = DEF_N_TASKS,
  parameter int unsigned LOOP_FIRST = DEF_LOOP_FIRST,
  parameter int unsigned LOOP_LAST  = DEF_LOOP_LAST,
  parameter int unsigned LOOP_CNT_W = DEF_LOOP_CNT_W,
  parameter int unsigned TIMEOUT_W  = DEF_TIMEOUT_W
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iStart,
  input  logic                         iAbort,
  input  logic [N_TASKS-1:0]           iSkipMask,
  input  logic                         iLoopExit,
  input  logic [TIMEOUT_W-1:0]         iTimeout,
  input  logic [N_TASKS-1:0]           iTaskDone,
  output logic [N_TASKS-1:0]           oTaskEn,
  output logic [clog2(N_TASKS)-1:0]    oCurTask,
  output logic [LOOP_CNT_W-1:0]        oLoopCnt,
  output logic                         oBusy,
  output logic                         oDone,
  output logic                         oErr,
  output logic [clog2(N_TASKS)-1:0]    oErrTask
);

  localparam int unsigned IDX_W = clog2(N_TASKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TASKS - 1);
  localparam logic [IDX_W-1:0] LOOP_F   = IDX_W'(LOOP_FIRST);
  localparam logic [IDX_W-1:0] LOOP_L   = IDX_W'(LOOP_LAST);

  state_e                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_cur, w_cur_nxt;
  logic [LOOP_CNT_W-1:0] r_loop_cnt, w_loop_cnt_nxt;
  logic [N_TASKS-1:0]    r_skip, w_skip_nxt;
  logic [N_TASKS-1:0]    r_task_en, w_task_en_nxt;
  logic [IDX_W-1:0]      r_err_task, w_err_task_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;

  logic w_idle_like;
  logic w_start_ok;
  logic w_cur_done;
  logic w_cur_skip;
  logic w_timeout;

  assign w_idle_like = (r_state == IDLE) || (r_state == DONE) || (r_state == ERR);
  assign w_start_ok  = iStart && !iAbort && w_idle_like;
  assign w_cur_done  = iTaskDone[r_cur];
  assign w_cur_skip  = r_skip[r_cur];

`ifdef TASK_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_limit;
  logic                 w_clear;
  logic                 w_run;
  logic                 w_expired;

  assign w_clear = (r_state == ISSUE);
  assign w_run   = (r_state == WAIT);

  // Limit is frozen for the whole run.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_limit <= '0;
    end else if (w_start_ok) begin
      r_limit <= iTimeout;
    end
  end

  task_timeout_counter #(
    .W (TIMEOUT_W)
  ) u_timeout (
    .i_clk       (iClk),
    .i_rst       (iRst),
    .i_clear     (w_clear),
    .i_run       (w_run),
    .i_limit     (r_limit),
    .o_expired_c (w_expired)
  );

  assign w_timeout = w_expired;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^iTimeout;
  assign w_timeout        = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      r_loop_cnt <= '0;
      r_skip     <= '0;
      r_task_en  <= '0;
      r_err_task <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_loop_cnt <= w_loop_cnt_nxt;
      r_skip     <= w_skip_nxt;
      r_task_en  <= w_task_en_nxt;
      r_err_task <= w_err_task_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (iAbort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE, ERR: if (iStart) w_state_nxt = ISSUE;
        ISSUE:           w_state_nxt = w_cur_skip ? NEXT : WAIT;
        WAIT: begin
          // Done takes priority over a timeout in the same cycle.
          if (w_cur_done)     w_state_nxt = NEXT;
          else if (w_timeout) w_state_nxt = ERR;
        end
        NEXT: begin
          if ((r_cur == LOOP_L) && !iLoopExit) w_state_nxt = ISSUE;
          else if (r_cur == LAST_IDX)          w_state_nxt = DONE;
          else                                 w_state_nxt = ISSUE;
        end
        default:         w_state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and run context.
  always_comb begin
    w_cur_nxt      = r_cur;
    w_loop_cnt_nxt = r_loop_cnt;
    w_skip_nxt     = r_skip;
    w_task_en_nxt  = r_task_en;
    w_err_task_nxt = r_err_task;
    if (iAbort) begin
      // Index, loop count and error task stay visible for debug.
      w_task_en_nxt = '0;
    end else begin
      case (r_state)
        IDLE, DONE, ERR: begin
          w_task_en_nxt = '0;
          if (iStart) begin
            w_cur_nxt      = '0;
            w_loop_cnt_nxt = '0;
            w_skip_nxt     = iSkipMask;
          end
        end
        ISSUE: begin
          if (!w_cur_skip) w_task_en_nxt = N_TASKS'(1) << r_cur;
        end
        WAIT: begin
          if (w_cur_done) begin
            w_task_en_nxt = '0;
          end else if (w_timeout) begin
            w_task_en_nxt  = '0;
            w_err_task_nxt = r_cur;
          end
        end
        NEXT: begin
          // Every pass through the window's last slot counts, exit or not.
          if ((r_cur == LOOP_L) && (r_loop_cnt != '1)) begin
            w_loop_cnt_nxt = r_loop_cnt + LOOP_CNT_W'(1);
          end
          if ((r_cur == LOOP_L) && !iLoopExit) w_cur_nxt = LOOP_F;
          else if (r_cur != LAST_IDX)          w_cur_nxt = r_cur + IDX_W'(1);
        end
        default: w_task_en_nxt = '0;
      endcase
    end
    w_busy_nxt = (w_state_nxt == ISSUE) || (w_state_nxt == WAIT) || (w_state_nxt == NEXT);
    w_done_nxt = (w_state_nxt == DONE);
    w_err_nxt  = (w_state_nxt == ERR);
  end

  assign oTaskEn  = r_task_en;
  assign oCurTask = r_cur;
  assign oLoopCnt = r_loop_cnt;
  assign oBusy    = r_busy;
  assign oDone    = r_done;
  assign oErr     = r_err;
  assign oErrTask = r_err_task;

endmodule

// File: tb/tb_task_step_sequencer.sv
// Bench for task_step_sequencer: run table plus hand-written abort/reset/done/timeout sequences.
// Timeout sequences depend on TASK_SEQ_TIMEOUT_EN.
module tb_task_step_sequencer;
  import task_seq_pkg::*;

  localparam int unsigned NT  = 6;
  localparam int unsigned LF  = 3;
  localparam int unsigned LL  = 4;
  localparam int unsigned LCW = 16;
  localparam int unsigned TW  = 24;
  localparam int unsigned IW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [NT-1:0]     skip_mask;
  logic              loop_exit;
  logic [TW-1:0]     timeout;
  logic [NT-1:0]     task_done;
  logic [NT-1:0]     man_done;
  logic [NT-1:0]     task_en;
  logic [IW-1:0]     cur_task;
  logic [LCW-1:0]    loop_cnt;
  logic              busy;
  logic              done;
  logic              err;
  logic [IW-1:0]     err_task;

  // Responder state
  logic [NT-1:0]     resp_done  = '0;
  logic [NT-1:0]     resp_hang  = '0;
  int                resp_delay = 5;
  int                resp_cnt [NT];

  // Loop-exit control and scoreboard
  int                repeats     = 0;
  int                pass_base   = 0;
  int                want_passes = 1;
  logic [NT-1:0]     prev_en     = '0;
  logic [IW-1:0]     prev_cur    = '0;
  int                exp_q [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign task_done = resp_done | man_done;
  assign loop_exit = ((repeats - pass_base) >= (want_passes - 1));

  task_step_sequencer #(
    .N_TASKS    (NT),
    .LOOP_FIRST (LF),
    .LOOP_LAST  (LL),
    .LOOP_CNT_W (LCW),
    .TIMEOUT_W  (TW)
  ) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iStart    (start),
    .iAbort    (abort),
    .iSkipMask (skip_mask),
    .iLoopExit (loop_exit),
    .iTimeout  (timeout),
    .iTaskDone (task_done),
    .oTaskEn   (task_en),
    .oCurTask  (cur_task),
    .oLoopCnt  (loop_cnt),
    .oBusy     (busy),
    .oDone     (done),
    .oErr      (err),
    .oErrTask  (err_task)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Done responders: raise done resp_delay cycles after enable, drop with enable.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NT; i++) begin
      if (task_en[i] !== 1'b1) begin
        resp_cnt[i]  = 0;
        resp_done[i] = 1'b0;
      end else if (!resp_done[i] && !resp_hang[i]) begin
        resp_cnt[i]++;
        if (resp_cnt[i] >= resp_delay) resp_done[i] = 1'b1;
      end
    end
  end

  // Scoreboard monitor: every rising enable must be the next expected task.
  always @(posedge clk) begin
    logic [NT-1:0] rise;
    int            idx;
    #1;
    rise = task_en & ~prev_en;
    if (rise != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_enable", 64'(rise), 64'd0);
      end else begin
        idx = exp_q.pop_front();
        check("enable_order", 64'(rise), 64'd1 << idx);
        check("cur_at_enable", 64'(cur_task), 64'(idx));
      end
    end
    if ((prev_cur == IW'(LL)) && (cur_task == IW'(LF))) repeats++;
    prev_en  = task_en;
    prev_cur = cur_task;
  end

  // Reference task order for a run.
  task automatic push_seq(input logic [NT-1:0] mask, input int passes);
    int i;
    int p;
    i = 0;
    p = 0;
    exp_q.delete();
    while (1'b1) begin
      if (!mask[i]) exp_q.push_back(i);
      if (i == LL) begin
        p++;
        if (p < passes) begin
          i = LF;
          continue;
        end
      end
      if (i == NT - 1) break;
      i++;
    end
  endtask

  task automatic begin_run(input logic [NT-1:0] mask, input int passes);
    want_passes = passes;
    pass_base   = repeats;
    skip_mask   = mask;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    skip_mask   = ~mask;
  endtask

  task automatic run_vec(input string tag, input logic [NT-1:0] mask, input int passes,
                         input int dly, input logic [LCW-1:0] exp_loop, input int exp_cyc,
                         input bit glitch);
    int n;
    push_seq(mask, passes);
    resp_delay = dly;
    begin_run(mask, passes);
    check({tag, "_busy_t1"}, 64'(busy), 64'd1);
    check({tag, "_en_t1"}, 64'(task_en), 64'd0);
    tick();
    n = 1;
    check({tag, "_en_t2"}, 64'(task_en), mask[0] ? 64'd0 : 64'd1);
    while (!done && n < 1000) begin
      if (glitch && n == 10) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    check({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
    check({tag, "_loopcnt"}, 64'(loop_cnt), 64'(exp_loop));
    check({tag, "_err"}, 64'(err), 64'd0);
    repeat (3) tick();
    check({tag, "_done_held"}, 64'({done, busy, task_en}), 64'({1'b1, 1'b0, 6'b0}));
    check({tag, "_cur_end"}, 64'(cur_task), 64'(NT - 1));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    string         tag;
    logic [NT-1:0] mask;
    int            passes;
    int            dly;
    logic [LCW-1:0] loops;
    int            cycles;
    bit            glitch;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n;
    vecs[0] = '{"plain",     6'b000000, 1, 5, 16'd1, 42, 1'b0};
    vecs[1] = '{"loop4",     6'b000000, 4, 2, 16'd4, 48, 1'b1};
    vecs[2] = '{"skip12",    6'b000110, 1, 3, 16'd1, 24, 1'b0};
    vecs[3] = '{"skip05",    6'b100001, 2, 1, 16'd2, 22, 1'b0};
    vecs[4] = '{"skipwin",   6'b011000, 2, 4, 16'd2, 32, 1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    skip_mask = '0;
    timeout   = '0;
    man_done  = '0;
    repeat (3) tick();
    check("reset_outputs", 64'({task_en, cur_task, loop_cnt, busy, done, err, err_task}), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_quiet", 64'({busy, task_en}), 64'd0);

    // Back-to-back runs; each one after the first starts from DONE.
    for (int k = 0; k < 5; k++) begin
      run_vec(vecs[k].tag, vecs[k].mask, vecs[k].passes, vecs[k].dly,
              vecs[k].loops, vecs[k].cycles, vecs[k].glitch);
    end

    // Abort in DONE: flag clears, loop count kept.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_flag", 64'({done, busy}), 64'd0);
    check("abort_done_loopcnt", 64'(loop_cnt), 64'd2);

    // Abort while task 3 is waiting.
    push_seq('0, 1);
    resp_delay = 2;
    resp_hang  = 6'b001000;
    begin_run('0, 1);
    n = 0;
    while (!task_en[3] && n < 200) begin
      tick();
      n++;
    end
    check("abort_reach_t3", 64'(task_en), 64'h08);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_en", 64'(task_en), 64'd0);
    check("abort_flags", 64'({busy, done, err}), 64'd0);
    check("abort_cur_kept", 64'(cur_task), 64'd3);
    check("abort_loopcnt_kept", 64'(loop_cnt), 64'd0);
    check("abort_queue", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    repeat (3) tick();
    check("abort_stays_idle", 64'({busy, task_en}), 64'd0);
    resp_hang = '0;

    // Abort together with start: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'd0);
    tick();
    check("abort_start_en", 64'(task_en), 64'd0);

    // Manual done: early done accepted at once, other tasks' done ignored.
    resp_hang = '1;
    man_done  = 6'b000001;
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(1);
    begin_run('0, 1);
    tick();
    check("early_done_en", 64'(task_en), 64'h01);
    tick();
    check("early_done_drop", 64'(task_en), 64'h00);
    man_done = 6'b111101;
    tick();
    tick();
    check("foreign_done_en1", 64'(task_en), 64'h02);
    repeat (5) tick();
    check("foreign_done_hold", 64'({busy, task_en}), 64'({1'b1, 6'b000010}));
    man_done = 6'b000010;
    tick();
    check("own_done_drop", 64'(task_en), 64'h00);
    check("manual_queue", 64'(exp_q.size()), 64'd0);
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    man_done = '0;
    resp_hang = '0;
    exp_q.delete();

    // Reset in mid-run.
    push_seq('0, 1);
    resp_delay = 5;
    begin_run('0, 1);
    n = 0;
    while (!task_en[1] && n < 200) begin
      tick();
      n++;
    end
    check("rst_reach_t1", 64'(task_en), 64'h02);
    rst = 1'b1;
    tick();
    check("rst_mid_outputs", 64'({task_en, cur_task, busy, done}), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    tick();

`ifdef TASK_SEQ_TIMEOUT_EN
    // Task 2 never completes: error after 10 waiting cycles.
    push_seq('0, 1);
    resp_delay = 2;
    resp_hang  = 6'b000100;
    timeout    = TW'(10);
    begin_run('0, 1);
    n = 0;
    while (!task_en[2] && n < 200) begin
      tick();
      n++;
    end
    check("to_reach_t2", 64'(task_en), 64'h04);
    repeat (9) tick();
    check("to_before_limit", 64'({err, task_en}), 64'({1'b0, 6'b000100}));
    tick();
    check("to_err", 64'({err, busy, task_en}), 64'({1'b1, 1'b0, 6'b0}));
    check("to_err_task", 64'(err_task), 64'd2);
    exp_q.delete();
    resp_hang = '0;
    // Restart from ERR; done on the 10th waiting cycle beats the timeout.
    run_vec("from_err", '0, 1, 10, 16'd1, 72, 1'b0);
    timeout = '0;
`else
    // Without the timeout the sequencer waits indefinitely.
    push_seq('0, 1);
    resp_delay = 2;
    resp_hang  = 6'b000100;
    timeout    = TW'(10);
    begin_run('0, 1);
    repeat (40) tick();
    check("no_to_wait", 64'({err, busy, task_en}), 64'({1'b0, 1'b1, 6'b000100}));
    check("no_to_err_task", 64'(err_task), 64'd0);
    abort = 1'b1;
    tick();
    abort     = 1'b0;
    resp_hang = '0;
    timeout   = '0;
    exp_q.delete();
`endif

    // Restart from IDLE after everything above.
    run_vec("final", 6'b000010, 1, 2, 16'd1, 22, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
